mmio_gpio_bank: RTL
===================

Name: mmio_gpio_bank

Overview:
- Parametrised memory-mapped GPIO bank for the single-cycle ARM core. It replaces the fixed single 8-bit in/out port pair at 0x800.
- Provides NCH channels of WIDTH bits each. Every channel has:
  - an output data register,
  - a per-bit direction register,
  - a 2-flop-synchronised input register,
  - a sticky rising-edge capture register with write-1-to-clear.
- Sits on the data-memory bus beside dmem. The top level muxes rdata into ReadData whenever hit=1.

Parameters:
- BASE_ADDR, 32'h800: byte address of channel 0, register 0. Must be 16-byte aligned.
- NCH, 2: number of channels, 1..8.
- WIDTH, 8: pins per channel, 1..32.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  32  byte address from the core (ALUResult)
- wdata  in  32  store data from the core (WriteData)
- we  in  1  store strobe (MemWrite)
- hit  out  1  addr falls in [BASE_ADDR, BASE_ADDR + 16*NCH)
- rdata  out  32  read data, combinational
- pin_in  in  NCH*WIDTH  external input pins, asynchronous to clk; channel c occupies bits [c*WIDTH +: WIDTH]
- pin_out  out  NCH*WIDTH  OUT registers, concatenated
- pin_oe  out  NCH*WIDTH  DIR registers, concatenated; 1 = pin driven
- irq  out  1  OR of all EDGE bits in all channels

Behaviour:
Address decode:
- Channel = (addr - BASE_ADDR) >> 4.
- Register offset = addr[3:2]: 0 = OUT (RW), 1 = IN (RO), 2 = DIR (RW), 3 = EDGE (RW1C).
- addr[1:0] is ignored.
- hit = 0 outside the window. When hit = 0: rdata = 0 and writes are ignored.

Reads:
- Combinational from registers, so the single-cycle core reads with zero latency.
- Value is zero-extended from WIDTH to 32 bits.
- Reads have no side effects.

Writes (on rising clk when we & hit):
- OUT <= wdata[WIDTH-1:0]
- DIR <= wdata[WIDTH-1:0]
- EDGE <= EDGE & ~wdata[WIDTH-1:0]
- Writes to IN are ignored.
- wdata bits above WIDTH are ignored.

Input path, every cycle, per channel:
- s1 <= pin_in, s2 <= s1, prev <= s2.
- IN = s2.
- rise = s2 & ~prev & ~DIR. Edges are captured only on bits configured as inputs.
- EDGE <= (EDGE & ~clr) | rise. Set wins over a same-cycle W1C on the same bit.

Latency:
- A pin change sampled at clk edge k appears in IN after edge k+1.
- The corresponding EDGE bit and irq appear after edge k+2.

irq is a combinational OR of EDGE flops. It is glitch-free because all of its sources are flops.

Reset (reset = 0, asynchronous):
- OUT, DIR, s1, s2, prev and EDGE all clear to 0.
- Resulting outputs: pin_out = 0, pin_oe = 0 (all pins inputs), irq = 0.
- A pin that is already high at reset release is captured as a rising edge 2 cycles after release. This is intended.
- Reset asserted mid-write: the write is lost and the registers clear.

Direction changes:
- Changing DIR does not alter the stored EDGE bits.
- Switching a bit to output stops new captures on that bit.

Decomposition:
- Package mmio_gpio_pkg holds:
  - register offset constants REG_OUT = 2'd0, REG_IN = 2'd1, REG_DIR = 2'd2, REG_EDGE = 2'd3,
  - CH_STRIDE = 16.
- Sub-module gpio_channel (parameter WIDTH): holds one channel's OUT, DIR, synchroniser, prev and EDGE logic, plus its read mux.
- mmio_gpio_bank instantiates NCH gpio_channel blocks via generate and adds:
  - the address decode,
  - the per-channel write-enable fan-out,
  - the read mux,
  - the irq OR.

Test Plan:
- Reset with pin_in = 0: release reset, then read 0x800, 0x808, 0x80C. All read 0; pin_out = 0, pin_oe = 0, irq = 0.
- Store 0xA5 to 0x800 and 0xF0 to 0x808: pin_out[7:0] = 0xA5 and pin_oe[7:0] = 0xF0 after the edge. Readback returns 0x000000A5 and 0x000000F0. Store 0x3C to 0x810 (channel 1 OUT): pin_out[15:8] = 0x3C, and channel 0 is unchanged.
- Drive pin_in[7:0] 0x00 -> 0x81 with DIR = 0x01: IN at 0x804 reads 0x81 two edges later. EDGE at 0x80C reads 0x80 (bit 0 is masked because it is an output). irq = 1.
- EDGE = 0x80: store 0x80 to 0x80C -> EDGE = 0, irq = 0. Repeat the store in the same cycle as a new rise on bit 7 -> EDGE stays 0x80.
- Store 0x55 to 0x820 (outside the window when NCH = 2): hit = 0, no register changes, rdata = 0. Store to 0x804: IN is unaffected.
- Assert reset asynchronously mid-cycle while OUT = 0xFF and EDGE = 0x0F: pin_out, EDGE and irq clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mmio_gpio_bank_pkg.sv
// Shared constants for the memory-mapped GPIO bank: register offsets within a
// channel and the byte stride between channels.
package mmio_gpio_pkg;

  localparam logic [1:0] REG_OUT  = 2'd0;
  localparam logic [1:0] REG_IN   = 2'd1;
  localparam logic [1:0] REG_DIR  = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  localparam int unsigned CH_STRIDE = 16;

endpackage

// File: rtl/mmio_gpio_bank_if.sv
// Data-memory bus slice seen by the GPIO bank: the core drives address, store
// data and strobe; the bank returns a window hit and combinational read data.
interface mmio_gpio_bank_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        hit;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input hit, input rdata);
  modport slave  (input addr, input wdata, input we, output hit, output rdata);

endinterface

// File: rtl/mmio_gpio_bank_gpio_channel.sv
// One GPIO channel: OUT and DIR registers, 2-flop input synchroniser, and a
// sticky rising-edge capture register with write-1-to-clear.
module gpio_channel
  import mmio_gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_we,
  input  logic [1:0]       i_reg,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_pin_in,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_dir,
  output logic [WIDTH-1:0] o_edge,
  output logic [31:0]      o_rdata
);

  logic [WIDTH-1:0] r_s1, r_s2, r_prev;
  logic [WIDTH-1:0] r_out, r_dir, r_edge;
  logic [WIDTH-1:0] w_rise, w_clr;

  // Only bits configured as inputs can capture an edge.
  assign w_rise = r_s2 & ~r_prev & ~r_dir;
  assign w_clr  = (i_we && (i_reg == REG_EDGE)) ? i_wdata : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
      r_out  <= '0;
      r_dir  <= '0;
      r_edge <= '0;
    end else begin
      r_s1   <= i_pin_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (i_we && (i_reg == REG_OUT)) r_out <= i_wdata;
      if (i_we && (i_reg == REG_DIR)) r_dir <= i_wdata;
      // Set wins over a same-cycle clear.
      r_edge <= (r_edge & ~w_clr) | w_rise;
    end
  end

  always_comb begin
    o_rdata = '0;
    unique case (i_reg)
      REG_OUT:  o_rdata[WIDTH-1:0] = r_out;
      REG_IN:   o_rdata[WIDTH-1:0] = r_s2;
      REG_DIR:  o_rdata[WIDTH-1:0] = r_dir;
      REG_EDGE: o_rdata[WIDTH-1:0] = r_edge;
      default:  o_rdata = '0;
    endcase
  end

  assign o_out  = r_out;
  assign o_dir  = r_dir;
  assign o_edge = r_edge;

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped bank of NCH GPIO channels on the data-memory bus: window
// decode, per-channel write enables, read mux and interrupt OR.
module mmio_gpio_bank
  import mmio_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h800,
  parameter int unsigned NCH       = 2,
  parameter int unsigned WIDTH     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mmio_gpio_bank_if.slave      bus,
  input  logic [NCH*WIDTH-1:0] i_pin_in,
  output logic [NCH*WIDTH-1:0] o_pin_out,
  output logic [NCH*WIDTH-1:0] o_pin_oe,
  output logic                 o_irq
);

  logic [31:0]          w_off;
  logic [27:0]          w_ch;
  logic                 w_hit;
  logic [NCH-1:0]       w_we;
  logic [NCH*WIDTH-1:0] w_edge;
  logic [31:0]          w_chan_rdata [NCH];
  logic [31:0]          w_rdata;

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
  assign w_off = bus.addr - BASE_ADDR;
  assign w_ch  = w_off[31:4];
  assign w_hit = (w_off < 32'(CH_STRIDE * NCH));

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_we[c] = bus.we & w_hit & (w_ch == 28'(c));

    gpio_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_we     (w_we[c]),
      .i_reg    (w_off[3:2]),
      .i_wdata  (bus.wdata[WIDTH-1:0]),
      .i_pin_in (i_pin_in[c*WIDTH +: WIDTH]),
      .o_out    (o_pin_out[c*WIDTH +: WIDTH]),
      .o_dir    (o_pin_oe[c*WIDTH +: WIDTH]),
      .o_edge   (w_edge[c*WIDTH +: WIDTH]),
      .o_rdata  (w_chan_rdata[c])
    );
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (w_hit && (w_ch == 28'(c))) w_rdata = w_chan_rdata[c];
    end
  end

  assign bus.hit   = w_hit;
  assign bus.rdata = w_rdata;
  assign o_irq     = |w_edge;

endmodule
